// File: rtl/flash_pkg.sv
// flash_pkg: op-type codes, SPI NOR command bytes and FSM states shared by flash_op_responder
package flash_pkg;
  localparam logic [1:0] P_OP_ERASE   = 2'd0;
  localparam logic [1:0] P_OP_PROGRAM = 2'd1;
  localparam logic [1:0] P_OP_READ    = 2'd2;
  localparam logic [7:0] C_WREN = 8'h06;
  localparam logic [7:0] C_SE   = 8'h20;
  localparam logic [7:0] C_PP   = 8'h02;
  localparam logic [7:0] C_READ = 8'h03;
  localparam logic [7:0] C_RDSR = 8'h05;
  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_CMD, S_ADDR, S_DATA, S_POLL_CMD, S_POLL_RD, S_WAIT, S_DONE
  } state_t;
endpackage

// File: rtl/flash_sync_fifo.sv
// flash_sync_fifo: 8-bit show-ahead synchronous FIFO; a push while full is accepted only alongside a pop
module flash_sync_fifo #(
  parameter int P_DEPTH = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int L_AW = $clog2(P_DEPTH);
  logic [7:0]  r_mem [P_DEPTH];
  logic [L_AW:0] r_wr;
  logic [L_AW:0] r_rd;
  logic w_push;
  logic w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full  = r_wr == {~r_rd[L_AW], r_rd[L_AW-1:0]};
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop) && !i_flush;
  assign o_data  = r_mem[r_rd[L_AW-1:0]];
  // storage write
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[L_AW-1:0]] <= i_data;
  end
  // pointers; flush empties the buffer and drops a same-cycle push
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + (L_AW+1)'(w_push);
      r_rd <= r_rd + (L_AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/flash_op_responder.sv
// flash_op_responder: sequences erase/program/read into SPI NOR bytes; FLASH_STATUS_POLL_EN selects RDSR polling instead of a fixed busy wait
module flash_op_responder
  import flash_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 256,
  parameter int P_BUSY_WAIT  = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_user_op_type,
  input  logic [23:0] i_user_op_addr,
  input  logic [8:0]  i_user_op_num,
  input  logic        i_user_op_valid,
  output logic        o_user_op_ready,
  input  logic [7:0]  i_user_write_data,
  input  logic        i_user_write_sop,
  input  logic        i_user_write_eop,
  input  logic        i_user_write_valid,
  output logic [7:0]  o_user_read_data,
  output logic        o_user_read_sop,
  output logic        o_user_read_eop,
  output logic        o_user_read_valid,
  output logic [7:0]  o_spi_byte,
  output logic        o_spi_valid,
  input  logic        i_spi_ready,
  output logic        o_spi_cs_hold,
  input  logic [7:0]  i_spi_rx_byte,
  input  logic        i_spi_rx_valid
);
`ifdef FLASH_STATUS_POLL_EN
  localparam state_t L_BUSY = S_POLL_CMD;
`else
  localparam state_t L_BUSY = S_WAIT;
  localparam int L_WW = $clog2(P_BUSY_WAIT + 1);
  logic [L_WW-1:0] r_wcnt;
`endif
  state_t r_state;
  state_t w_next;
  logic [1:0]  r_type;
  logic [23:0] r_addr;
  logic [8:0]  r_num;
  logic [8:0]  r_cnt;
  logic [1:0]  r_idx;
  logic        r_wait_rx;
  logic        r_ready;
  logic        r_rd_valid;
  logic        r_rd_sop;
  logic        r_rd_eop;
  logic [7:0]  r_rd_data;
  logic        w_op_hs;
  logic        w_skip;
  logic [8:0]  w_num_in;
  logic        w_tx_state;
  logic        w_stall;
  logic        w_tx_hs;
  logic        w_rx;
  logic        w_last_data;
  logic        w_rd_hit;
  logic        w_fifo_empty;
  logic        w_fifo_full;
  logic [7:0]  w_fifo_data;
  logic        w_unused;
  assign w_unused    = &{1'b0, i_user_write_sop, i_user_write_eop, w_fifo_full};
  assign w_op_hs     = i_user_op_valid && r_ready;
  assign w_skip      = i_user_op_type != P_OP_ERASE && (i_user_op_type == 2'd3 || i_user_op_num == 9'd0);
  assign w_num_in    = (i_user_op_type == P_OP_PROGRAM && i_user_op_num > 9'd256) ? 9'd256 : i_user_op_num;
  assign w_tx_state  = r_state inside {S_WREN, S_CMD, S_ADDR, S_DATA, S_POLL_CMD, S_POLL_RD};
  assign w_stall     = r_state == S_DATA && r_type == P_OP_PROGRAM && w_fifo_empty;
  assign w_tx_hs     = o_spi_valid && i_spi_ready;
  assign w_rx        = r_wait_rx && i_spi_rx_valid;
  assign w_last_data = r_cnt == r_num - 9'd1;
  assign w_rd_hit    = r_state == S_DATA && r_type == P_OP_READ && w_rx;
  assign o_user_op_ready   = r_ready;
  assign o_user_read_valid = r_rd_valid;
  assign o_user_read_data  = r_rd_data;
  assign o_user_read_sop   = r_rd_sop;
  assign o_user_read_eop   = r_rd_eop;
  flash_sync_fifo #(.P_DEPTH(P_FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (r_state == S_DONE),
    .i_push  (i_user_write_valid),
    .i_data  (i_user_write_data),
    .i_pop   (w_tx_hs && r_state == S_DATA && r_type == P_OP_PROGRAM),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );
  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next state: each tx state advances only once its rx byte has come back
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_op_hs) w_next = w_skip ? S_DONE : (i_user_op_type == P_OP_READ ? S_CMD : S_WREN);
      S_WREN:     if (w_rx) w_next = S_CMD;
      S_CMD:      if (w_rx) w_next = S_ADDR;
      S_ADDR:     if (w_rx && r_idx == 2'd2) w_next = r_type == P_OP_ERASE ? L_BUSY : S_DATA;
      S_DATA:     if (w_rx && w_last_data) w_next = r_type == P_OP_READ ? S_DONE : L_BUSY;
      S_POLL_CMD: if (w_rx) w_next = S_POLL_RD;
      S_POLL_RD:  if (w_rx) w_next = i_spi_rx_byte[0] ? S_POLL_CMD : S_DONE;
`ifndef FLASH_STATUS_POLL_EN
      S_WAIT:     if (r_wcnt == L_WW'(P_BUSY_WAIT - 1)) w_next = S_DONE;
`endif
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end
  // SPI byte, chip-select hold and valid decoded from state and counters
  always_comb begin
    o_spi_valid   = w_tx_state && !r_wait_rx && !w_stall;
    o_spi_byte    = 8'h00;
    o_spi_cs_hold = 1'b0;
    case (r_state)
      S_WREN: o_spi_byte = C_WREN;
      S_CMD: begin
        o_spi_byte    = r_type == P_OP_ERASE ? C_SE : (r_type == P_OP_PROGRAM ? C_PP : C_READ);
        o_spi_cs_hold = 1'b1;
      end
      S_ADDR: begin
        o_spi_byte    = r_idx == 2'd0 ? r_addr[23:16] : (r_idx == 2'd1 ? r_addr[15:8] : r_addr[7:0]);
        o_spi_cs_hold = !(r_idx == 2'd2 && r_type == P_OP_ERASE);
      end
      S_DATA: begin
        o_spi_byte    = r_type == P_OP_PROGRAM ? w_fifo_data : 8'h00;
        o_spi_cs_hold = !w_last_data;
      end
      S_POLL_CMD: begin
        o_spi_byte    = C_RDSR;
        o_spi_cs_hold = 1'b1;
      end
      default: ;
    endcase
  end
  // op latch, in-flight flag, byte/address counters, ready and read stream
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_type     <= 2'd0;
      r_addr     <= 24'd0;
      r_num      <= 9'd0;
      r_cnt      <= 9'd0;
      r_idx      <= 2'd0;
      r_wait_rx  <= 1'b0;
      r_ready    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_sop   <= 1'b0;
      r_rd_eop   <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      if (w_op_hs) begin
        r_type <= i_user_op_type;
        r_addr <= i_user_op_addr;
        r_num  <= w_num_in;
      end
      r_wait_rx  <= w_tx_hs ? 1'b1 : (w_rx ? 1'b0 : r_wait_rx);
      r_idx      <= r_state == S_ADDR ? r_idx + {1'b0, w_rx} : 2'd0;
      r_cnt      <= r_state == S_DATA ? r_cnt + {8'd0, w_rx} : 9'd0;
      r_ready    <= w_next == S_IDLE;
      r_rd_valid <= w_rd_hit;
      r_rd_sop   <= w_rd_hit && r_cnt == 9'd0;
      r_rd_eop   <= w_rd_hit && w_last_data;
      if (w_rd_hit) r_rd_data <= i_spi_rx_byte;
    end
  end
`ifndef FLASH_STATUS_POLL_EN
  // busy-wait cycle counter, only running in WAIT
  always_ff @(posedge i_clk) begin
    if (i_rst) r_wcnt <= '0;
    else r_wcnt <= r_state == S_WAIT ? r_wcnt + L_WW'(1) : '0;
  end
`endif
endmodule

// File: tb/tb_flash_op_responder.sv
// tb_flash_op_responder: directed bench with a one-byte-in-flight SPI engine model
module tb_flash_op_responder;
  localparam int BW = 20;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op_type = 2'd0;
  logic [23:0] op_addr = 24'd0;
  logic [8:0]  op_num = 9'd0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_sop = 1'b0, wr_eop = 1'b0, wr_valid = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_sop, rd_eop, rd_valid;
  logic [7:0]  spi_byte;
  logic        spi_valid, spi_hold;
  logic        spi_ready = 1'b0;
  logic [7:0]  spi_rx = 8'h00;
  logic        spi_rx_valid = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] g_b, c_d;
  logic g_h, g_ok, g_after, c_v, c_s, c_e;

  flash_op_responder #(.P_FIFO_DEPTH(256), .P_BUSY_WAIT(BW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_user_op_type(op_type), .i_user_op_addr(op_addr), .i_user_op_num(op_num),
    .i_user_op_valid(op_valid), .o_user_op_ready(op_ready),
    .i_user_write_data(wr_data), .i_user_write_sop(wr_sop), .i_user_write_eop(wr_eop),
    .i_user_write_valid(wr_valid),
    .o_user_read_data(rd_data), .o_user_read_sop(rd_sop), .o_user_read_eop(rd_eop),
    .o_user_read_valid(rd_valid),
    .o_spi_byte(spi_byte), .o_spi_valid(spi_valid), .i_spi_ready(spi_ready),
    .o_spi_cs_hold(spi_hold), .i_spi_rx_byte(spi_rx), .i_spi_rx_valid(spi_rx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] rx);
    int n = 0;
    while (!spi_valid && n < 200) begin
      tick();
      n++;
    end
    g_ok = spi_valid;
    g_b  = spi_byte;
    g_h  = spi_hold;
    spi_ready = 1'b1;
    tick();
    spi_ready = 1'b0;
    g_after = spi_valid;
    spi_rx = rx;
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    c_v = rd_valid;
    c_d = rd_data;
    c_s = rd_sop;
    c_e = rd_eop;
  endtask

  task automatic start_op(input logic [1:0] t, input logic [23:0] a, input logic [8:0] n);
    op_type = t;
    op_addr = a;
    op_num = n;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_data = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n, output logic quiet);
    n = 0;
    quiet = 1'b1;
    while (!op_ready && n < BW + 60) begin
      tick();
      n++;
      if (spi_valid) quiet = 1'b0;
    end
  endtask

  task automatic finish_busy(input string nm, input int polls);
    int n;
    logic q;
`ifdef FLASH_STATUS_POLL_EN
    for (int p = 0; p < polls; p++) begin
      xfer(8'h00);
      checks++;
      if (!g_ok || g_b !== 8'h05 || g_h !== 1'b1)
        $display("FAIL %s rdsr_cmd%0d got %02h/%0b want 05/1", nm, p, g_b, g_h);
      if (!g_ok || g_b !== 8'h05 || g_h !== 1'b1) errors++;
      xfer(p == polls - 1 ? 8'h00 : 8'h01);
      checks++;
      if (!g_ok || g_b !== 8'h00 || g_h !== 1'b0) begin
        errors++;
        $display("FAIL %s rdsr_rd%0d got %02h/%0b want 00/0", nm, p, g_b, g_h);
      end
    end
    wait_ready(n, q);
    checks++;
    if (n !== 1 || !q) begin
      errors++;
      $display("FAIL %s ready_after_poll got %0d cycles quiet=%0b want 1 quiet=1", nm, n, q);
    end
`else
    wait_ready(n, q);
    checks++;
    if (n !== BW + 1 || !q) begin
      errors++;
      $display("FAIL %s ready_after_wait got %0d cycles quiet=%0b want %0d quiet=1", nm, n, q, BW + 1);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", op_ready);
    end
    checks++;
    if ({spi_valid, spi_hold, spi_byte} !== 10'd0) begin
      errors++;
      $display("FAIL reset_spi got v=%0b h=%0b b=%02h want 0", spi_valid, spi_hold, spi_byte);
    end
    checks++;
    if ({rd_valid, rd_sop, rd_eop, rd_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_read got v=%0b s=%0b e=%0b d=%02h want 0", rd_valid, rd_sop, rd_eop, rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_erase(input logic [23:0] a, input string nm);
    logic [7:0] eb [5];
    logic eh [5];
    eb = '{8'h06, 8'h20, a[23:16], a[15:8], a[7:0]};
    eh = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    start_op(2'd0, a, 9'd0);
    checks++;
    if (spi_valid !== 1'b1 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s start got valid=%0b ready=%0b want 1/0", nm, spi_valid, op_ready);
    end
    for (int i = 0; i < 5; i++) begin
      xfer(8'hFF);
      checks++;
      if (!g_ok || g_b !== eb[i] || g_h !== eh[i] || g_after !== 1'b0) begin
        errors++;
        $display("FAIL %s byte%0d got %02h/%0b after=%0b want %02h/%0b after=0", nm, i, g_b, g_h, g_after, eb[i], eh[i]);
      end
    end
    finish_busy(nm, 3);
  endtask

  task automatic test_program();
    logic [7:0] eb [7];
    logic eh [7];
    eb = '{8'h06, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    eh = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    start_op(2'd1, 24'd0, 9'd2);
    fork
      begin
        wr_data = 8'h01; wr_sop = 1'b1; wr_valid = 1'b1;
        tick();
        wr_data = 8'h02; wr_sop = 1'b0; wr_eop = 1'b1;
        tick();
        wr_valid = 1'b0; wr_eop = 1'b0;
      end
      begin
        for (int i = 0; i < 7; i++) begin
          xfer(8'hFF);
          checks++;
          if (!g_ok || g_b !== eb[i] || g_h !== eh[i]) begin
            errors++;
            $display("FAIL program byte%0d got %02h/%0b want %02h/%0b", i, g_b, g_h, eb[i], eh[i]);
          end
        end
      end
    join
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL program ready_busy got %0b want 0", op_ready);
    end
    finish_busy("program", 1);
  endtask

  task automatic test_read(input logic [8:0] num, input string nm);
    int n;
    logic q;
    logic [7:0] eb, rx;
    logic eh;
    int j;
    start_op(2'd2, 24'd0, num);
    for (int k = 0; k < 4 + int'(num); k++) begin
      j = k - 4;
      eb = k == 0 ? 8'h03 : 8'h00;
      eh = !(k == 3 + int'(num));
      rx = k < 4 ? 8'hFF : 8'hAA + 8'(8'h11 * j);
      xfer(rx);
      checks++;
      if (!g_ok || g_b !== eb || g_h !== eh) begin
        errors++;
        $display("FAIL %s tx%0d got %02h/%0b want %02h/%0b", nm, k, g_b, g_h, eb, eh);
      end
      checks++;
      if (k < 4 ? (c_v !== 1'b0) : (c_v !== 1'b1 || c_d !== rx || c_s !== (j == 0) || c_e !== (j == int'(num) - 1))) begin
        errors++;
        $display("FAIL %s rd%0d got v=%0b d=%02h s=%0b e=%0b want v=%0b d=%02h s=%0b e=%0b",
                 nm, k, c_v, c_d, c_s, c_e, k >= 4, rx, j == 0, j == int'(num) - 1);
      end
    end
    wait_ready(n, q);
    checks++;
    if (n !== 1 || !q) begin
      errors++;
      $display("FAIL %s ready got %0d cycles quiet=%0b want 1 quiet=1", nm, n, q);
    end
  endtask

  task automatic test_zero(input logic [1:0] t, input logic [8:0] num, input string nm);
    int n;
    logic q;
    start_op(t, 24'h00ABCD, num);
    checks++;
    if (spi_valid !== 1'b0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s start got valid=%0b ready=%0b want 0/0", nm, spi_valid, op_ready);
    end
    wait_ready(n, q);
    checks++;
    if (n < 1 || n > 3 || !q) begin
      errors++;
      $display("FAIL %s ready got %0d cycles quiet=%0b want 1..3 quiet=1", nm, n, q);
    end
  endtask

  task automatic test_stall();
    logic [7:0] eb [5];
    logic [7:0] d [3];
    logic seen;
    eb = '{8'h06, 8'h02, 8'h00, 8'h01, 8'h00};
    d = '{8'hA1, 8'hB2, 8'hC3};
    start_op(2'd1, 24'h000100, 9'd3);
    for (int i = 0; i < 5; i++) begin
      xfer(8'hFF);
      checks++;
      if (!g_ok || g_b !== eb[i]) begin
        errors++;
        $display("FAIL stall hdr%0d got %02h want %02h", i, g_b, eb[i]);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (spi_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL stall empty_valid got 1 want 0");
    end
    for (int i = 0; i < 3; i++) push(d[i]);
    for (int i = 0; i < 3; i++) begin
      xfer(8'hFF);
      checks++;
      if (!g_ok || g_b !== d[i] || g_h !== (i != 2)) begin
        errors++;
        $display("FAIL stall data%0d got %02h/%0b want %02h/%0b", i, g_b, g_h, d[i], i != 2);
      end
    end
    finish_busy("stall", 1);
  endtask

  task automatic test_clamp();
    logic [7:0] eb [5];
    eb = '{8'h06, 8'h02, 8'h0A, 8'h0B, 8'h0C};
    for (int i = 0; i < 257; i++) push(i < 256 ? 8'(i) : 8'hEE);
    start_op(2'd1, 24'h0A0B0C, 9'd300);
    for (int i = 0; i < 5; i++) begin
      xfer(8'hFF);
      checks++;
      if (!g_ok || g_b !== eb[i]) begin
        errors++;
        $display("FAIL clamp hdr%0d got %02h want %02h", i, g_b, eb[i]);
      end
    end
    for (int i = 0; i < 256; i++) begin
      xfer(8'hFF);
      checks++;
      if (!g_ok || g_b !== 8'(i) || g_h !== (i != 255)) begin
        errors++;
        $display("FAIL clamp data%0d got %02h/%0b want %02h/%0b", i, g_b, g_h, 8'(i), i != 255);
      end
    end
    finish_busy("clamp", 1);
  endtask

  task automatic test_flush();
    logic seen;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    start_op(2'd1, 24'd0, 9'd1);
    for (int i = 0; i < 5; i++) xfer(8'hFF);
    xfer(8'hFF);
    checks++;
    if (!g_ok || g_b !== 8'h11 || g_h !== 1'b0) begin
      errors++;
      $display("FAIL flush first got %02h/%0b want 11/0", g_b, g_h);
    end
    finish_busy("flush1", 1);
    start_op(2'd1, 24'd0, 9'd1);
    for (int i = 0; i < 5; i++) xfer(8'hFF);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (spi_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush surplus_left got valid=1 want 0");
    end
    push(8'h44);
    xfer(8'hFF);
    checks++;
    if (!g_ok || g_b !== 8'h44) begin
      errors++;
      $display("FAIL flush second got %02h want 44", g_b);
    end
    finish_busy("flush2", 1);
  endtask

  task automatic test_reset_mid();
    start_op(2'd2, 24'h00FF00, 9'd2);
    xfer(8'hFF);
    xfer(8'hFF);
    checks++;
    if (spi_valid !== 1'b1 || spi_byte !== 8'hFF) begin
      errors++;
      $display("FAIL rst_mid pre got valid=%0b byte=%02h want 1/ff", spi_valid, spi_byte);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (spi_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid post got valid=%0b ready=%0b want 0/1", spi_valid, op_ready);
    end
    rst = 1'b0;
    tick();
    test_erase(24'h123456, "erase_after_rst");
  endtask

  initial begin
    test_reset();
    test_erase(24'h000000, "erase");
    test_program();
    test_read(9'd2, "read2");
    test_read(9'd1, "read1");
    test_zero(2'd2, 9'd0, "read_num0");
    test_zero(2'd1, 9'd0, "prog_num0");
    test_zero(2'd3, 9'd5, "reserved");
    test_stall();
    test_clamp();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
